ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 122 ++++++++++++
 tb/tb_ifetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch: single-outstanding memory requests feeding an in-order {pc, instr} queue.
// Define IFETCH_SKID_EN for a 2-entry queue (full rate with a strict space check); default 1 entry.
module ifetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] ir,
   output logic [15:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_pc
);

`ifdef IFETCH_SKID_EN
   localparam int unsigned Depth = 2;
`else
   localparam int unsigned Depth = 1;
`endif

   logic [15:0] fetch_pc_q, fetch_pc_d;
   logic [15:0] req_addr_q, req_addr_d;
   logic        outst_q, outst_d;
   logic        drop_q, drop_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] pc_q [Depth];
   logic [15:0] pc_d [Depth];
   logic [15:0] instr_q [Depth];
   logic [15:0] instr_d [Depth];

   logic        pop;
   logic        push;
   logic        accept;
   logic        has_space;
   logic [1:0]  cnt_pop;

   assign ir_valid = (cnt_q != 2'd0);
   assign ir       = instr_q[0];
   assign ir_pc    = pc_q[0];
   assign pop      = ir_valid && ir_ready;

`ifdef IFETCH_SKID_EN
   assign has_space = (cnt_q < 2'd2);
`else
   // A slot frees up this cycle when the single entry is being consumed.
   assign has_space = (cnt_q == 2'd0) || pop;
`endif

   // An outstanding request is held through redirects until it is acked.
   assign imem_req  = !rst && (outst_q || (has_space && !redirect));
   assign imem_addr = outst_q ? req_addr_q : fetch_pc_q;
   assign accept    = imem_req && imem_ack;
   assign push      = accept && !drop_q && !redirect;
   assign cnt_pop   = cnt_q - {1'b0, pop};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_addr_d = imem_addr;
      outst_d    = imem_req && !imem_ack;
      drop_d     = drop_q;
      cnt_d      = cnt_pop;
      pc_d       = pc_q;
      instr_d    = instr_q;

      if (accept) begin
         drop_d = 1'b0;
      end else if (redirect && outst_q) begin
         drop_d = 1'b1;
      end

      if (pop) begin
         for (int i = 0; i < int'(Depth) - 1; i++) begin
            pc_d[i]    = pc_q[i+1];
            instr_d[i] = instr_q[i+1];
         end
      end

      if (push) begin
         for (int i = 0; i < int'(Depth); i++) begin
            if (i == int'(cnt_pop)) begin
               pc_d[i]    = imem_addr;
               instr_d[i] = imem_rdata;
            end
         end
         cnt_d      = cnt_pop + 2'd1;
         fetch_pc_d = imem_addr + 16'd1;
      end

      if (redirect) begin
         cnt_d      = 2'd0;
         fetch_pc_d = redirect_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         outst_q    <= 1'b0;
         drop_q     <= 1'b0;
         cnt_q      <= 2'd0;
         for (int i = 0; i < int'(Depth); i++) begin
            pc_q[i]    <= 16'h0000;
            instr_q[i] <= 16'h0000;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: queue-based reference model checked every cycle, an in-order stream check,
// and directed literal expectations for reset, stall, redirect and wrap scenarios.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] ir;
   logic [15:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect;
   logic [15:0] redirect_pc;

   logic        mem_ready;
   logic        ack_force;

   always #5 clk = ~clk;

   // Memory: zero-wait when mem_ready, data is a fixed function of the address.
   assign imem_ack   = ack_force | (imem_req & mem_ready);
   assign imem_rdata = imem_addr ^ 16'hA5A5;

   ifetch #(
      .RESET_PC(16'h0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .ir_pc      (ir_pc),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready),
      .redirect   (redirect),
      .redirect_pc(redirect_pc)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ins;
   } ent_t;

   ent_t        mq[$];
   logic [15:0] m_pc;
   logic [15:0] m_addr;
   bit          m_out;
   bit          m_drop;
   bit          m_rst;
   bit          chk_en = 1'b0;
   logic [15:0] nxt_pc;

   always @(negedge clk) begin : mon
      bit          pop_e;
      bit          space;
      bit          exp_req;
      bit          exp_valid;
      bit          acc;
      logic [15:0] exp_addr;

      exp_valid = (mq.size() > 0);
      pop_e     = exp_valid && ir_ready;
`ifdef IFETCH_SKID_EN
      space = (mq.size() + (m_out ? 1 : 0)) < 2;
`else
      space = (mq.size() == 0) || pop_e;
`endif
      exp_req  = !rst && (m_out || (space && !redirect));
      exp_addr = m_out ? m_addr : m_pc;
      acc      = exp_req && (mem_ready || ack_force);

      if (chk_en) begin
         chk("imem_req", imem_req, exp_req);
         if (exp_req) chk("imem_addr", imem_addr, exp_addr);
         chk("ir_valid", ir_valid, exp_valid);
         if (exp_valid) begin
            chk("ir", ir, mq[0].ins);
            chk("ir_pc", ir_pc, mq[0].pc);
         end
         if (m_rst) begin
            chk("ir_rst", ir, 16'h0000);
            chk("ir_pc_rst", ir_pc, 16'h0000);
         end
         // Consumed stream must be in order, restarting at the redirect/reset target.
         if (!rst && ir_valid && ir_ready) chk("order", ir_pc, nxt_pc);
      end

      if (rst) begin
         nxt_pc = 16'h0000;
      end else begin
         if (ir_valid === 1'b1 && ir_ready) nxt_pc = ir_pc + 16'd1;
         if (redirect) nxt_pc = redirect_pc;
      end

      if (rst) begin
         mq.delete();
         m_pc   = 16'h0000;
         m_addr = 16'h0000;
         m_out  = 1'b0;
         m_drop = 1'b0;
         m_rst  = 1'b1;
         chk_en = 1'b1;
      end else begin
         m_rst = 1'b0;
         if (pop_e) void'(mq.pop_front());
         if (acc) begin
            if (!m_drop && !redirect) begin
               mq.push_back({exp_addr, exp_addr ^ 16'hA5A5});
               m_pc = exp_addr + 16'd1;
            end
            m_out  = 1'b0;
            m_drop = 1'b0;
         end else if (exp_req) begin
            m_out  = 1'b1;
            m_addr = exp_addr;
            if (redirect) m_drop = 1'b1;
         end
         if (redirect) begin
            mq.delete();
            m_pc = redirect_pc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      mem_ready   = 1'b1;
      ack_force   = 1'b0;
      ir_ready    = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;

      // Reset values, then zero-wait streaming from RESET_PC.
      step();
      @(negedge clk);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", ir_valid, 1'b0);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_ir_pc", ir_pc, 16'h0000);
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("first_req", imem_req, 1'b1);
      chk("first_addr", imem_addr, 16'h0000);
      chk("c1_valid", ir_valid, 1'b0);
      step();
      @(negedge clk);
      chk("c2_valid", ir_valid, 1'b1);
      chk("c2_ir_pc", ir_pc, 16'h0000);
      chk("c2_ir", ir, 16'hA5A5);
      step();
      @(negedge clk);
      chk("c3_ir_pc", ir_pc, 16'h0001);
      chk("c3_ir", ir, 16'hA5A4);
      repeat (10) step();

      // Decoder stall: requests stop once the queue is full.
      ir_ready = 1'b0;
      repeat (4) step();
      @(negedge clk);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_valid", ir_valid, 1'b1);
      repeat (6) step();
      ir_ready = 1'b1;
      repeat (6) step();

      // Redirect while a request is outstanding: old data dropped, then 0x0200.
      mem_ready = 1'b0;
      step();
      redirect    = 1'b1;
      redirect_pc = 16'h0200;
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("drop_valid", ir_valid, 1'b0);
      chk("drop_req_held", imem_req, 1'b1);
      step();
      mem_ready = 1'b1;
      step();
      @(negedge clk);
      chk("redir_req", imem_req, 1'b1);
      chk("redir_addr", imem_addr, 16'h0200);
      chk("redir_valid0", ir_valid, 1'b0);
      step();
      @(negedge clk);
      chk("redir_valid", ir_valid, 1'b1);
      chk("redir_ir_pc", ir_pc, 16'h0200);
      chk("redir_ir", ir, 16'hA7A5);
      repeat (5) step();

      // Redirect coincident with ack and pop.
      mem_ready = 1'b0;
      step();
      mem_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      @(negedge clk);
      chk("coin_ack", imem_ack, 1'b1);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("coin_valid0", ir_valid, 1'b0);
      chk("coin_addr", imem_addr, 16'h0040);
      step();
      @(negedge clk);
      chk("coin_ir_pc", ir_pc, 16'h0040);
      chk("coin_ir", ir, 16'hA5E5);
      repeat (3) step();

      // Address wrap.
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("wrap_addr", imem_addr, 16'hFFFE);
      step();
      @(negedge clk);
      chk("wrap0_pc", ir_pc, 16'hFFFE);
      chk("wrap0_ir", ir, 16'h5A5B);
      step();
      @(negedge clk);
      chk("wrap1_pc", ir_pc, 16'hFFFF);
      chk("wrap1_ir", ir, 16'h5A5A);
      step();
      @(negedge clk);
      chk("wrap2_pc", ir_pc, 16'h0000);
      chk("wrap2_ir", ir, 16'hA5A5);
      step();
      @(negedge clk);
      chk("wrap3_pc", ir_pc, 16'h0001);
      repeat (3) step();

      // Reset with a request outstanding and an ack arriving during reset.
      mem_ready = 1'b0;
      step();
      step();
      rst       = 1'b1;
      ack_force = 1'b1;
      mem_ready = 1'b1;
      step();
      @(negedge clk);
      chk("rsta_valid", ir_valid, 1'b0);
      chk("rsta_req", imem_req, 1'b0);
      step();
      ack_force = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
      chk("rsta_first_addr", imem_addr, 16'h0000);
      chk("rsta_valid1", ir_valid, 1'b0);
      step();
      @(negedge clk);
      chk("rsta_ir_pc", ir_pc, 16'h0000);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         ir_ready    = ($urandom_range(0, 3) != 0);
         mem_ready   = ($urandom_range(0, 9) < 6);
         redirect    = ($urandom_range(0, 24) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                                   : 16'($urandom);
         rst         = ($urandom_range(0, 199) == 0);
         step();
      end
      rst       = 1'b0;
      redirect  = 1'b0;
      mem_ready = 1'b1;
      ir_ready  = 1'b1;
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
